// File: rtl/uart_rx_ctrl.sv
// UART receive control: baud tick generator, frame-state tracking, deferred config update and receive FIFO.
// Tick and config outputs are registered; FIFO head (o_data/o_par_err) is combinational with a 1-cycle push-to-valid latency.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int FIFO_AW = 3,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_cfg_wr,
  input  logic [DIV_W-1:0]   i_cfg_div,
  input  logic [1:0]         i_cfg_num_bit,
  input  logic               i_cfg_stop_bit,
  input  logic               i_cfg_par_en,
  input  logic               i_cfg_par_type,
  input  logic               i_rx_serial,
  input  logic               i_rx_done,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_par_err,
  output logic               o_rx_tick,
  output logic [1:0]         o_num_bit_data,
  output logic               o_stop_bit,
  output logic               o_parity_en,
  output logic               o_parity_type,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [7:0]         o_data,
  output logic               o_par_err,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_overrun,
  input  logic               i_clr_err,
  output logic               o_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_DISABLED, S_IDLE, S_BUSY} state_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [1:0]       nb;
    logic             stop;
    logic             pen;
    logic             ptype;
  } cfg_t;

  localparam cfg_t CFG_RST = '{div: DIV_W'(325), nb: 2'b11, stop: 1'b0, pen: 1'b0, ptype: 1'b0};

  state_t             r_state;
  cfg_t               r_act, r_shadow;
  logic               r_pending;
  logic [DIV_W-1:0]   r_tick_cnt;
  logic               r_rx_tick, r_busy, r_overrun;
  logic               r_ser_q, r_ser_qq;
  logic [8:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;

  cfg_t w_cfg_in;
  logic w_fall, w_done_ok, w_pop, w_full, w_push, w_ovf, w_xfer;

  assign w_cfg_in  = '{div: i_cfg_div, nb: i_cfg_num_bit, stop: i_cfg_stop_bit,
                       pen: i_cfg_par_en, ptype: i_cfg_par_type};
  assign w_fall    = r_ser_qq & ~r_ser_q;
  assign w_done_ok = i_rx_done && (r_state != S_DISABLED);
  assign w_pop     = o_valid && i_ready;
  assign w_full    = (r_level == DEPTH_L);
  assign w_push    = w_done_ok && (!w_full || w_pop);
  assign w_ovf     = w_done_ok && w_full && !w_pop;
  // Outside a frame the active config may change at once; inside, only at the frame boundary.
  assign w_xfer    = (r_state != S_BUSY) || i_rx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act     <= CFG_RST;
      r_shadow  <= CFG_RST;
      r_pending <= 1'b0;
    end else begin
      if (i_cfg_wr) r_shadow <= w_cfg_in;
      if (w_xfer) begin
        if (i_cfg_wr)       r_act <= w_cfg_in;
        else if (r_pending) r_act <= r_shadow;
        r_pending <= 1'b0;
      end else if (i_cfg_wr) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_rx_tick  <= 1'b0;
    end else if (!i_en) begin
      r_tick_cnt <= '0;
      r_rx_tick  <= 1'b0;
    end else if (r_tick_cnt >= r_act.div) begin
      r_tick_cnt <= '0;
      r_rx_tick  <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + DIV_W'(1);
      r_rx_tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_DISABLED;
      r_busy   <= 1'b0;
      r_ser_q  <= 1'b1;
      r_ser_qq <= 1'b1;
    end else begin
      r_ser_q  <= i_rx_serial;
      r_ser_qq <= r_ser_q;
      if (!i_en) begin
        r_state <= S_DISABLED;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_DISABLED: r_state <= S_IDLE;
          S_IDLE: if (w_fall) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
          end
          S_BUSY: if (i_rx_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_DISABLED;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_rx_par_err, i_rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_ovf)          r_overrun <= 1'b1;
      else if (i_clr_err) r_overrun <= 1'b0;
    end
  end

  assign o_rx_tick      = r_rx_tick;
  assign o_num_bit_data = r_act.nb;
  assign o_stop_bit     = r_act.stop;
  assign o_parity_en    = r_act.pen;
  assign o_parity_type  = r_act.ptype;
  assign o_busy         = r_busy;
  assign o_level        = r_level;
  assign o_overrun      = r_overrun;
  assign o_valid        = (r_level != '0);
  assign o_data         = r_mem[r_rptr][7:0];
  assign o_par_err      = r_mem[r_rptr][8];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus, popped FIFO entries checked against a queue of expected {par_err, data}.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_cfg_wr = 1'b0;
  logic [15:0] i_cfg_div = 16'd325;
  logic [1:0]  i_cfg_num_bit = 2'b11;
  logic        i_cfg_stop_bit = 1'b0;
  logic        i_cfg_par_en = 1'b0;
  logic        i_cfg_par_type = 1'b0;
  logic        i_rx_serial = 1'b1;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_par_err = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_clr_err = 1'b0;
  logic        o_rx_tick, o_stop_bit, o_parity_en, o_parity_type;
  logic [1:0]  o_num_bit_data;
  logic        o_valid, o_par_err, o_overrun, o_busy;
  logic [7:0]  o_data;
  logic [3:0]  o_level;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cycle = 0;
  logic [8:0]  exp_q[$];

  uart_rx_ctrl #(.FIFO_AW(3), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_cfg_wr(i_cfg_wr), .i_cfg_div(i_cfg_div),
    .i_cfg_num_bit(i_cfg_num_bit), .i_cfg_stop_bit(i_cfg_stop_bit), .i_cfg_par_en(i_cfg_par_en),
    .i_cfg_par_type(i_cfg_par_type), .i_rx_serial(i_rx_serial), .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data), .i_rx_par_err(i_rx_par_err), .o_rx_tick(o_rx_tick),
    .o_num_bit_data(o_num_bit_data), .o_stop_bit(o_stop_bit), .o_parity_en(o_parity_en),
    .o_parity_type(o_parity_type), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_par_err(o_par_err), .o_level(o_level), .o_overrun(o_overrun), .i_clr_err(i_clr_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Every accepted pop must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got %0h, expected nothing (t=%0t)", {o_par_err, o_data}, $time);
      end else begin
        check("pop_data", 32'({o_par_err, o_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] nb, input logic pen);
    i_cfg_div = 16'd325; i_cfg_num_bit = nb; i_cfg_stop_bit = 1'b0;
    i_cfg_par_en = pen; i_cfg_par_type = 1'b0; i_cfg_wr = 1'b1;
    step(1);
    i_cfg_wr = 1'b0;
  endtask

  task automatic done_pulse(input logic [7:0] d, input logic pe);
    i_rx_data = d; i_rx_par_err = pe; i_rx_done = 1'b1;
    step(1);
    i_rx_done = 1'b0;
  endtask

  task automatic start_frame();
    i_rx_serial = 1'b0;
    step(3);
    i_rx_serial = 1'b1;
  endtask

  task automatic wait_tick(output int cyc, output logic ok);
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_rx_tick) begin
        cyc = cycle; ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   t1, t2, nticks;
    logic ok1, ok2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tick",   32'(o_rx_tick), 0);
    check("rst_busy",   32'(o_busy), 0);
    check("rst_valid",  32'(o_valid), 0);
    check("rst_level",  32'(o_level), 0);
    check("rst_ovr",    32'(o_overrun), 0);
    check("rst_nb",     32'(o_num_bit_data), 3);
    check("rst_pen",    32'(o_parity_en), 0);
    check("rst_div",    32'(dut.r_act.div), 325);
    rst_n = 1'b1;
    step(2);

    // Tick period with the default divisor
    i_en = 1'b1;
    wait_tick(t1, ok1);
    wait_tick(t2, ok2);
    check("tick_seen", 32'(ok1 & ok2), 1);
    check("tick_period", 32'(t2 - t1), 326);

    // Disabled: no ticks and counter held at zero
    i_en = 1'b0;
    step(2);
    nticks = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_rx_tick) nticks++;
    end
    check("tick_disabled", 32'(nticks), 0);
    check("tick_cnt_zero", 32'(dut.r_tick_cnt), 0);
    i_en = 1'b1;
    step(2);

    // Config write in IDLE is visible after one cycle
    cfg_write(2'b01, 1'b0);
    @(negedge clk);
    check("idle_cfg_nb", 32'(o_num_bit_data), 1);

    // Config write in BUSY waits for the frame end
    i_ready = 1'b1;
    start_frame();
    @(negedge clk);
    check("busy_set", 32'(o_busy), 1);
    step(0);
    @(posedge clk); #1;
    cfg_write(2'b00, 1'b1);
    @(negedge clk);
    check("defer_nb_hold",  32'(o_num_bit_data), 1);
    check("defer_pen_hold", 32'(o_parity_en), 0);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h5A});
    i_rx_data = 8'h5A; i_rx_par_err = 1'b0; i_rx_done = 1'b1;
    @(negedge clk);
    check("defer_nb_at_done", 32'(o_num_bit_data), 1);
    @(posedge clk); #1;
    i_rx_done = 1'b0;
    @(negedge clk);
    check("defer_nb_after", 32'(o_num_bit_data), 0);
    check("defer_pen_after", 32'(o_parity_en), 1);
    check("busy_clear", 32'(o_busy), 0);
    step(3);

    // FIFO ordering with the consumer stalled, then draining
    i_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hA5}); done_pulse(8'hA5, 1'b0);
    exp_q.push_back({1'b1, 8'h03}); done_pulse(8'h03, 1'b1);
    exp_q.push_back({1'b0, 8'h1F}); done_pulse(8'h1F, 1'b0);
    @(negedge clk);
    check("order_level3", 32'(o_level), 3);
    check("order_head", 32'({o_par_err, o_data}), 32'h0A5);
    @(posedge clk); #1;
    i_ready = 1'b1;
    step(5);
    i_ready = 1'b0;
    @(negedge clk);
    check("order_level0", 32'(o_level), 0);
    check("order_all_popped", 32'(exp_q.size()), 0);

    // Overrun: ninth frame dropped
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({1'b0, 8'(8'h10 + i)});
      done_pulse(8'(8'h10 + i), 1'b0);
    end
    @(negedge clk);
    check("ovr_level8", 32'(o_level), 8);
    check("ovr_flag", 32'(o_overrun), 1);
    check("ovr_head", 32'(o_data), 32'h10);
    @(posedge clk); #1;
    i_clr_err = 1'b1; i_rx_data = 8'h77; i_rx_done = 1'b1;
    step(1);
    i_clr_err = 1'b0; i_rx_done = 1'b0;
    @(negedge clk);
    check("ovr_set_wins", 32'(o_overrun), 1);
    check("ovr_level_hold", 32'(o_level), 8);
    @(posedge clk); #1;
    i_clr_err = 1'b1;
    step(1);
    i_clr_err = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(o_overrun), 0);

    // Full FIFO with simultaneous push and pop
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h99});
    i_ready = 1'b1; i_rx_data = 8'h99; i_rx_done = 1'b1;
    step(1);
    i_ready = 1'b0; i_rx_done = 1'b0;
    @(negedge clk);
    check("full_pp_level", 32'(o_level), 8);
    check("full_pp_ovr", 32'(o_overrun), 0);
    check("full_pp_head", 32'(o_data), 32'h11);

    // Drain to two entries, then reset in the middle of a frame
    @(posedge clk); #1;
    i_ready = 1'b1;
    step(6);
    i_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_level2", 32'(o_level), 2);
    @(posedge clk); #1;
    start_frame();
    cfg_write(2'b10, 1'b1);
    @(negedge clk);
    check("pre_rst_busy", 32'(o_busy), 1);
    check("pre_rst_pending", 32'(dut.r_pending), 1);
    @(posedge clk); #1;
    i_rx_data = 8'hEE; i_rx_done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy",  32'(o_busy), 0);
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_level", 32'(o_level), 0);
    check("mid_rst_ovr",   32'(o_overrun), 0);
    check("mid_rst_tick",  32'(o_rx_tick), 0);
    check("mid_rst_nb",    32'(o_num_bit_data), 3);
    check("mid_rst_pen",   32'(o_parity_en), 0);
    check("mid_rst_stop",  32'({o_stop_bit, o_parity_type}), 0);
    check("mid_rst_div",   32'(dut.r_act.div), 325);
    check("mid_rst_pend",  32'(dut.r_pending), 0);
    step(2);
    i_rx_done = 1'b0;
    @(negedge clk);
    check("rst_no_write", 32'(o_level), 0);
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
